// File: rtl/branch_pkg.sv
// Shared branch-prediction types: 2-bit counter encoding, its reset value and the gshare hash.
// Used by the PHT, the history register and the fetch/execute stages.
package branch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e BP_CTR_RST = WNT;

    // Word-aligned PC bits XOR zero-extended history; callers keep the low INDEX_WIDTH bits.
    function automatic logic [31:0] gshare_idx(input logic [31:0] pc, input logic [31:0] ghr);
        return {2'b00, pc[31:2]} ^ ghr;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One 2-bit saturating branch counter, asynchronously reset to weakly-not-taken.
// inc and dec together (or neither) leave the counter unchanged.
module bp_sat_ctr
    import branch_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    en,
    input  logic    inc,
    input  logic    dec,
    output bp_ctr_e ctr
);

    bp_ctr_e ctr_next;

    always_comb begin
        ctr_next = ctr;
        if (en) begin
            if (inc && !dec && ctr != ST) begin
                ctr_next = bp_ctr_e'(ctr + 2'b01);
            end else if (dec && !inc && ctr != SNT) begin
                ctr_next = bp_ctr_e'(ctr - 2'b01);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctr <= BP_CTR_RST;
        end else begin
            ctr <= ctr_next;
        end
    end

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: predicts from PC XOR global history, trains at execute,
// and keeps saturating branch / mispredict counters for the CSRs.
module gshare_pht
    import branch_pkg::*;
#(
    parameter int INDEX_WIDTH   = 8,
    parameter int HISTORY_WIDTH = 8,
    parameter int PERF_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              pc_i,
    input  logic [HISTORY_WIDTH-1:0] ghr_data_i,
    output logic                     pred_taken_o,
    output logic [INDEX_WIDTH-1:0]   pred_idx_o,
    input  logic                     update_en_i,
    input  logic [INDEX_WIDTH-1:0]   update_idx_i,
    input  logic                     br_taken_i,
    input  logic                     update_pred_i,
    output logic                     mispredict_o,
    output logic [PERF_WIDTH-1:0]    br_count_o,
    output logic [PERF_WIDTH-1:0]    mispred_count_o
);

    localparam int NUM_ENTRIES = 1 << INDEX_WIDTH;

    if (HISTORY_WIDTH > INDEX_WIDTH) begin : g_bad_history
        $error("gshare_pht: HISTORY_WIDTH must not exceed INDEX_WIDTH");
    end

    bp_ctr_e ctr_tab [NUM_ENTRIES];
    logic    mispredict_now;

    assign pred_idx_o   = INDEX_WIDTH'(gshare_idx(pc_i, 32'(ghr_data_i)));
    // Read sees the pre-update counter; a same-cycle write becomes visible next cycle.
    assign pred_taken_o = ctr_tab[pred_idx_o][1];

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ctr
        bp_sat_ctr u_ctr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en     (update_en_i && (update_idx_i == INDEX_WIDTH'(g))),
            .inc    (br_taken_i),
            .dec    (!br_taken_i),
            .ctr    (ctr_tab[g])
        );
    end

    assign mispredict_now = update_en_i && (update_pred_i != br_taken_i);

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispredict_o    <= 1'b0;
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else begin
            mispredict_o <= mispredict_now;
            if (update_en_i && br_count_o != '1) begin
                br_count_o <= br_count_o + 1'b1;
            end
            if (mispredict_now && mispred_count_o != '1) begin
                mispred_count_o <= mispred_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_pht.sv
// Randomised bench for gshare_pht against an array-of-integers reference model.
// Small perf counters so saturation is reached within a short run.
module tb_gshare_pht;

    localparam int IW = 4;
    localparam int HW = 4;
    localparam int PW = 6;
    localparam int PERF_MAX = (1 << PW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [31:0]   pc_i;
    logic [HW-1:0] ghr_data_i;
    logic          pred_taken_o;
    logic [IW-1:0] pred_idx_o;
    logic          update_en_i;
    logic [IW-1:0] update_idx_i;
    logic          br_taken_i;
    logic          update_pred_i;
    logic          mispredict_o;
    logic [PW-1:0] br_count_o;
    logic [PW-1:0] mispred_count_o;

    int ctr_m [16];
    int br_m;
    int mis_m;
    int misp_m;
    int n_checks = 0;
    int n_errors = 0;

    gshare_pht #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW), .PERF_WIDTH(PW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pc_i            (pc_i),
        .ghr_data_i      (ghr_data_i),
        .pred_taken_o    (pred_taken_o),
        .pred_idx_o      (pred_idx_o),
        .update_en_i     (update_en_i),
        .update_idx_i    (update_idx_i),
        .br_taken_i      (br_taken_i),
        .update_pred_i   (update_pred_i),
        .mispredict_o    (mispredict_o),
        .br_count_o      (br_count_o),
        .mispred_count_o (mispred_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int model_idx(input logic [31:0] pc, input logic [HW-1:0] ghr);
        return ((pc / 4) ^ int'(ghr)) % 16;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ctr_m[i] = 1;
        br_m   = 0;
        mis_m  = 0;
        misp_m = 0;
    endtask

    // Called just after a falling edge: drive, check the read, clock, check the update results.
    task automatic applyStimulus(input logic [31:0] pc, input logic [HW-1:0] ghr, input logic en,
                                 input logic [IW-1:0] idx, input logic taken, input logic pred);
        int r;
        pc_i          = pc;
        ghr_data_i    = ghr;
        update_en_i   = en;
        update_idx_i  = idx;
        br_taken_i    = taken;
        update_pred_i = pred;
        #1;
        r = model_idx(pc, ghr);
        checkOutput("pred_idx", 32'(pred_idx_o), r);
        checkOutput("pred_taken", 32'(pred_taken_o), (ctr_m[r] >= 2) ? 1 : 0);
        @(posedge clk_i);
        if (en) begin
            if (taken) ctr_m[idx] = (ctr_m[idx] == 3) ? 3 : ctr_m[idx] + 1;
            else       ctr_m[idx] = (ctr_m[idx] == 0) ? 0 : ctr_m[idx] - 1;
            if (br_m < PERF_MAX) br_m++;
            misp_m = (pred != taken) ? 1 : 0;
            if (misp_m == 1 && mis_m < PERF_MAX) mis_m++;
        end else begin
            misp_m = 0;
        end
        @(negedge clk_i);
        checkOutput("mispredict", 32'(mispredict_o), misp_m);
        checkOutput("br_count", 32'(br_count_o), br_m);
        checkOutput("mispred_count", 32'(mispred_count_o), mis_m);
    endtask

    initial begin
        int r;
        logic [IW-1:0] ridx;
        rst_ni = 1'b0;
        pc_i = '0; ghr_data_i = '0; update_en_i = 1'b0; update_idx_i = '0;
        br_taken_i = 1'b0; update_pred_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        checkOutput("reset_br_count", 32'(br_count_o), 0);
        checkOutput("reset_mispredict", 32'(mispredict_o), 0);
        rst_ni = 1'b1;

        applyStimulus(32'h10, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("idx_0x10", 32'(pred_idx_o), 4);
        applyStimulus(32'h3C, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("idx_0x3c", 32'(pred_idx_o), 32'b1010);

        applyStimulus(32'h0, 4'h0, 1'b1, 4'd7, 1'b1, 1'b0);
        checkOutput("counts_after_miss", {br_count_o, mispred_count_o}, {6'd1, 6'd1});
        applyStimulus(32'h0, 4'h0, 1'b1, 4'd7, 1'b0, 1'b0);
        checkOutput("counts_after_hit", {br_count_o, mispred_count_o}, {6'd2, 6'd1});

        for (int i = 0; i < 3; i++) applyStimulus(32'hC, 4'h0, 1'b1, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(32'hC, 4'h0, 1'b1, 4'd3, 1'b0, 1'b1);
        applyStimulus(32'hC, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("idx3_back_to_nt", 32'(pred_taken_o), 0);
        applyStimulus(32'h8, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(32'h10, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 4'h0, 1'b1, 4'd0, 1'b0, 1'b0);
        applyStimulus(32'h0, 4'h0, 1'b1, 4'd0, 1'b1, 1'b0);
        applyStimulus(32'h0, 4'h0, 1'b1, 4'd0, 1'b1, 1'b0);
        applyStimulus(32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("idx0_taken_after_two", 32'(pred_taken_o), 1);

        for (int i = 0; i < 150; i++) begin
            ridx = IW'($urandom_range(15));
            r = int'(ridx);
            applyStimulus($urandom, HW'($urandom), ($urandom_range(3) != 0), ridx,
                          1'($urandom), ($urandom_range(1) == 0) ? (ctr_m[r] >= 2) : 1'($urandom));
        end

        pc_i = 32'hC; ghr_data_i = 4'h0;
        update_en_i = 1'b1; update_idx_i = 4'd5; br_taken_i = 1'b1; update_pred_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        checkOutput("async_rst_mispredict", 32'(mispredict_o), 0);
        checkOutput("async_rst_br_count", 32'(br_count_o), 0);
        checkOutput("async_rst_mispred_count", 32'(mispred_count_o), 0);
        checkOutput("async_rst_pred", 32'(pred_taken_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_hold_br_count", 32'(br_count_o), 0);
        checkOutput("rst_hold_mispredict", 32'(mispredict_o), 0);
        rst_ni = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(32'(i * 4), 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(32'(i * 4), 4'h0, 1'b1, IW'(i), 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom, HW'($urandom), 1'b1, IW'($urandom_range(15)), 1'b1, 1'b0);
        end
        checkOutput("br_count_saturated", 32'(br_count_o), PERF_MAX);
        checkOutput("mispred_count_saturated", 32'(mispred_count_o), PERF_MAX);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
